i2c_frame_receiver: RTL and testbench

//  I2C responder (slave) on FPGA B; receiving end of FPGA A's 104-bit I2C result frame.

---
 rtl/i2c_frame_pkg.sv | 32 +++
 rtl/i2c_bus_sync.sv | 58 +++++
 rtl/i2c_frame_receiver.sv | 182 ++++++++++++++++++
 tb/tb_i2c_frame_receiver.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_frame_pkg.sv
// Shared definitions for the I2C frame receiver.
// A frame is 104 bits: {header[5:0], opcode[1:0], a[31:0], b[31:0], result[31:0]},
// sent as 13 bytes with the most significant byte first.
package i2c_frame_pkg;

    localparam int unsigned FRAME_BITS = 104;

    // Header value that a well-formed frame carries in bits [103:98]
    localparam logic [5:0] ACK_START = 6'b111111;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_WAIT_STOP
    } state_e;

    typedef struct packed {
        logic [5:0]  header;
        logic [1:0]  opcode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
    } frame_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and decodes bus events.
// Ports:
//   clk_i, reset_i      system clock, synchronous active-high reset
//   scl_i, sda_i        raw bus levels
//   sda_o               synchronised SDA, aligned with the event strobes
//   scl_rise_o/fall_o   one-cycle SCL edge strobes
//   start_o/stop_o      one-cycle START / STOP condition strobes
// Every output is registered, so events appear SYNC_STAGES+1 clk after the bus change.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];
    assign sda_o = sda_hist_q;

    // Synchroniser chains reset to the idle-bus level so no edge is invented on release
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_o <= 1'b0;
            scl_fall_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
        end else begin
            scl_sync_q <= SYNC_STAGES'({scl_sync_q, scl_i});
            sda_sync_q <= SYNC_STAGES'({sda_sync_q, sda_i});
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
            scl_rise_o <= scl_s & ~scl_hist_q;
            scl_fall_o <= ~scl_s & scl_hist_q;
            // SDA may only move while SCL is high for START/STOP
            start_o    <= scl_s & scl_hist_q & sda_hist_q & ~sda_s;
            stop_o     <= scl_s & scl_hist_q & ~sda_hist_q & sda_s;
        end
    end

endmodule

// File: rtl/i2c_frame_receiver.sv
// I2C responder receiving a 13-byte result frame and presenting its decoded fields.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   i2c_scl           bus clock, only ever read (no clock stretching)
//   i2c_sda           open-drain data, pulled low only while acknowledging
//   frame_valid       one-cycle strobe: opcode/a/b/result just updated
//   frame_err         one-cycle strobe: addressed transfer ended short, overran or was malformed
//   opcode, a, b, result  decoded fields of the last valid frame
//   busy              high from address match until STOP, repeated START or reset
// Build option: define I2C_FRAME_HEADER_CHECK_EN to reject frames whose header is not 6'b111111.
module i2c_frame_receiver
    import i2c_frame_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
    parameter int unsigned FRAME_BYTES = 13,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire         i2c_scl,
    inout  wire         i2c_sda,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [1:0]  opcode,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [31:0] result,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(FRAME_BYTES + 2);

`ifdef I2C_FRAME_HEADER_CHECK_EN
    localparam bit HDR_CHECK = 1'b1;
`else
    localparam bit HDR_CHECK = 1'b0;
`endif

    state_e                state_q;
    logic [3:0]            bit_cnt_q;
    logic [CNT_W-1:0]      byte_cnt_q;
    logic [6:0]            shift_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic                  sda_oe_q;
    logic                  overrun_q;

    logic                  sda_s;
    logic                  scl_rise;
    logic                  scl_fall;
    logic                  start_det;
    logic                  stop_det;
    logic [7:0]            byte_w;
    frame_t                frame_w;
    logic                  frame_ok;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i      (clk),
        .reset_i    (reset),
        .scl_i      (i2c_scl),
        .sda_i      (i2c_sda),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

    // Byte as it stands once the bit sampled on this SCL rise is included
    assign byte_w  = {shift_q, sda_s};
    assign frame_w = frame_t'(frame_q);

    assign frame_ok = (byte_cnt_q == CNT_W'(FRAME_BYTES)) && !overrun_q &&
                      (!HDR_CHECK || (frame_w.header == ACK_START));

    // Receive FSM; bus conditions take priority over bit/ACK handling in every state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            frame_q     <= '0;
            sda_oe_q    <= 1'b0;
            overrun_q   <= 1'b0;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            opcode      <= '0;
            a           <= '0;
            b           <= '0;
            result      <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (stop_det) begin
                if (busy) begin
                    if (frame_ok) begin
                        frame_valid <= 1'b1;
                        opcode      <= frame_w.opcode;
                        a           <= frame_w.a;
                        b           <= frame_w.b;
                        result      <= frame_w.result;
                    end else begin
                        frame_err   <= 1'b1;
                    end
                end
                state_q    <= ST_IDLE;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                sda_oe_q   <= 1'b0;
                overrun_q  <= 1'b0;
                busy       <= 1'b0;
            end else if (start_det) begin
                // Repeated START throws away whatever partial frame was in flight
                frame_err  <= busy;
                state_q    <= ST_ADDR;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                sda_oe_q   <= 1'b0;
                overrun_q  <= 1'b0;
                busy       <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= byte_w[6:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= '0;
                                if (byte_w == {SLAVE_ADDR, 1'b0}) begin
                                    state_q <= ST_ADDR_ACK;
                                    busy    <= 1'b1;
                                end else begin
                                    state_q <= ST_WAIT_STOP;
                                end
                            end
                        end
                    end

                    // First SCL fall pulls SDA low, the next one releases it
                    ST_ADDR_ACK, ST_DATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= ST_DATA;
                            end
                        end
                    end

                    // Bytes are committed whole, so the SCL pulse of a STOP/Sr never disturbs frame_q
                    ST_DATA: begin
                        if (scl_rise) begin
                            shift_q   <= byte_w[6:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= '0;
                                if (byte_cnt_q < CNT_W'(FRAME_BYTES)) begin
                                    frame_q    <= {frame_q[FRAME_BITS-9:0], byte_w};
                                    byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                                    state_q    <= ST_DATA_ACK;
                                end else begin
                                    overrun_q  <= 1'b1;
                                    state_q    <= ST_WAIT_STOP;
                                end
                            end
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_frame_receiver.sv
// Bench for i2c_frame_receiver: a bit-level I2C master drives directed transfers, a
// frame-level model predicts ACKs, pulses and output fields, and a per-cycle monitor
// compares the DUT outputs against the model.
module tb_i2c_frame_receiver;
    import i2c_frame_pkg::*;

    localparam int Q = 4;
    localparam int H = 8;

    logic        clk;
    logic        reset;
    logic        scl_drv;
    logic        sda_low;
    wire         i2c_scl;
    wire         i2c_sda;
    logic        frame_valid;
    logic        frame_err;
    logic [1:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        busy;

    int          tests;
    int          fails;
    int          valid_cnt;
    int          err_cnt;
    bit          chk_en;
    bit          busy_seen;
    bit          pend_valid;
    logic [97:0] pend;
    logic [97:0] exp_fields;
    logic [7:0]  txq[$];

    assign i2c_scl = scl_drv;
    assign i2c_sda = sda_low ? 1'b0 : 1'bz;
    pullup (i2c_sda);

    i2c_frame_receiver dut (
        .clk         (clk),
        .reset       (reset),
        .i2c_scl     (i2c_scl),
        .i2c_sda     (i2c_sda),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .opcode      (opcode),
        .a           (a),
        .b           (b),
        .result      (result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle monitor: outputs may only move together with frame_valid
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_fields = '0;
                pend_valid = 1'b0;
            end else if (chk_en) begin
                if (frame_valid) begin
                    valid_cnt++;
                    check("frame_valid was predicted", 104'(pend_valid), 104'd1);
                    if (pend_valid) begin
                        exp_fields = pend;
                        pend_valid = 1'b0;
                    end
                end
                if (frame_err) err_cnt++;
                if (busy) busy_seen = 1'b1;
                check("outputs vs model", {6'd0, frame_valid & frame_err, opcode, a, b, result},
                      {6'd0, 1'b0, exp_fields});
            end
        end
    end

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_low = 1'b0; scl_drv = 1'b1; cyc(H);
        sda_low = 1'b1; cyc(H);
        scl_drv = 1'b0; cyc(Q);
    endtask

    task automatic bus_restart();
        sda_low = 1'b0; cyc(Q);
        scl_drv = 1'b1; cyc(H);
        sda_low = 1'b1; cyc(H);
        scl_drv = 1'b0; cyc(Q);
    endtask

    task automatic bus_stop();
        sda_low = 1'b1; cyc(Q);
        scl_drv = 1'b1; cyc(H);
        sda_low = 1'b0; cyc(H);
    endtask

    task automatic send_bits(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_low = !d[i]; cyc(Q);
            scl_drv = 1'b1;  cyc(H);
            scl_drv = 1'b0;  cyc(Q);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, output bit ack);
        send_bits(d);
        sda_low = 1'b0; cyc(Q);
        scl_drv = 1'b1; cyc(H / 2);
        ack = (i2c_sda === 1'b0);
        cyc(H / 2);
        scl_drv = 1'b0; cyc(Q);
    endtask

    function automatic logic [103:0] mk_frame(input logic [5:0] h, input logic [1:0] op,
                                              input logic [31:0] fa, input logic [31:0] fb,
                                              input logic [31:0] fr);
        return {h, op, fa, fb, fr};
    endfunction

    task automatic load_q(input logic [103:0] f, input int n);
        txq.delete();
        for (int i = 0; i < n; i++) txq.push_back(f[103 - 8 * i -: 8]);
    endtask

    function automatic bit header_ok(input logic [103:0] f);
`ifdef I2C_FRAME_HEADER_CHECK_EN
        return f[103:98] == 6'b111111;
`else
        return f[103:98] == f[103:98];
`endif
    endfunction

    // One transfer of txq; term 0 ends with STOP, 1 with repeated START
    task automatic xfer(input string name, input logic [6:0] addr, input bit do_start,
                        input int term, output bit last_ack);
        bit          ack;
        bit          addressed;
        bit          exp_v;
        bit          exp_e;
        int          acks;
        int          exp_acks;
        int          n;
        int          v0;
        int          e0;
        logic [103:0] fr;

        n         = txq.size();
        addressed = (addr == 7'h42);
        exp_acks  = addressed ? 1 + ((n < 13) ? n : 13) : 0;
        fr        = '0;
        if (n >= 13)
            for (int i = 0; i < 13; i++) fr = {fr[95:0], txq[i]};
        exp_v = addressed && (term == 0) && (n == 13) && header_ok(fr);
        exp_e = addressed && !exp_v;
        if (exp_v) begin
            pend       = fr[97:0];
            pend_valid = 1'b1;
        end

        v0 = valid_cnt; e0 = err_cnt; acks = 0; busy_seen = 1'b0; last_ack = 1'b0;
        if (do_start) bus_start();
        send_byte({addr, 1'b0}, ack);
        acks += int'(ack);
        for (int i = 0; i < n; i++) begin
            send_byte(txq[i], ack);
            acks += int'(ack);
            last_ack = ack;
        end
        if (term == 0) bus_stop(); else bus_restart();
        cyc(30);

        check({name, " ack count"}, 104'(acks), 104'(exp_acks));
        check({name, " frame_valid cycles"}, 104'(valid_cnt - v0), 104'(exp_v));
        check({name, " frame_err cycles"}, 104'(err_cnt - e0), 104'(exp_e));
        check({name, " busy seen"}, 104'(busy_seen), 104'(addressed));
        check({name, " busy after end"}, 104'(busy), 104'd0);
    endtask

    initial begin
        bit last;
        bit ack;
        int v0;
        int e0;

        tests = 0; fails = 0; valid_cnt = 0; err_cnt = 0;
        chk_en = 1'b0; pend_valid = 1'b0; pend = '0; exp_fields = '0;
        reset = 1'b1; scl_drv = 1'b1; sda_low = 1'b0;
        cyc(5);
        #1;
        check("reset opcode", 104'(opcode), 104'd0);
        check("reset a", 104'(a), 104'd0);
        check("reset result", 104'(result), 104'd0);
        check("reset busy/valid/err", 104'({busy, frame_valid, frame_err}), 104'd0);
        check("reset sda released", 104'(i2c_sda), 104'd1);
        reset = 1'b0;
        chk_en = 1'b1;
        cyc(10);

        // 1: valid ADD frame
        load_q(mk_frame(6'h3F, OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000), 13);
        xfer("s1", 7'h42, 1'b1, 0, last);
        check("s1 opcode", 104'(opcode), 104'd0);
        check("s1 a", 104'(a), 104'h3F800000);
        check("s1 b", 104'(b), 104'h40000000);
        check("s1 result", 104'(result), 104'h40400000);

        // 2: wrong address is ignored
        xfer("s2", 7'h43, 1'b1, 0, last);

        // 3: short frame
        load_q(mk_frame(6'h3F, OP_SUB, 32'h11111111, 32'h22222222, 32'h33333333), 5);
        xfer("s3", 7'h42, 1'b1, 0, last);
        check("s3 a held", 104'(a), 104'h3F800000);

        // 4: overrun, byte 14 NACKed
        load_q(mk_frame(6'h3F, OP_SUB, 32'h44444444, 32'h55555555, 32'h66666666), 13);
        txq.push_back(8'h77);
        xfer("s4", 7'h42, 1'b1, 0, last);
        check("s4 byte 14 NACK", 104'(last), 104'd0);
        check("s4 result held", 104'(result), 104'h40400000);

        // 5: repeated START after 6 bytes, then a full SUB frame
        load_q(mk_frame(6'h3F, OP_MUL, 32'h99999999, 32'h88888888, 32'h77777777), 6);
        xfer("s5a", 7'h42, 1'b1, 1, last);
        load_q(mk_frame(6'h3F, OP_SUB, 32'd5, 32'd3, 32'd2), 13);
        xfer("s5b", 7'h42, 1'b0, 0, last);
        check("s5 opcode", 104'(opcode), 104'd1);
        check("s5 a", 104'(a), 104'd5);

        // 6: reset while the DUT is acknowledging byte 4
        load_q(mk_frame(6'h3F, OP_MUL, 32'd6, 32'd7, 32'd42), 13);
        v0 = valid_cnt; e0 = err_cnt;
        bus_start();
        send_byte({7'h42, 1'b0}, ack);
        for (int i = 0; i < 3; i++) send_byte(txq[i], ack);
        send_bits(txq[3]);
        sda_low = 1'b0; cyc(Q);
        @(negedge clk);
        check("s6 ack driven before reset", 104'(i2c_sda), 104'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("s6 sda released next clk", 104'(i2c_sda), 104'd1);
        check("s6 fields cleared", 104'({opcode, a, b, result}), 104'd0);
        check("s6 busy/valid/err", 104'({busy, frame_valid, frame_err}), 104'd0);
        check("s6 no pulses", 104'({valid_cnt - v0, err_cnt - e0}), 104'd0);
        scl_drv = 1'b1;
        cyc(10);
        reset = 1'b0;
        cyc(10);
        xfer("s6", 7'h42, 1'b1, 0, last);
        check("s6 opcode", 104'(opcode), 104'd2);
        check("s6 result", 104'(result), 104'd42);

        // 7: bad header
        load_q(mk_frame(6'h2A, OP_ADD, 32'd1, 32'd1, 32'd2), 13);
        xfer("s7", 7'h42, 1'b1, 0, last);
`ifdef I2C_FRAME_HEADER_CHECK_EN
        check("s7 result held", 104'(result), 104'd42);
`else
        check("s7 result", 104'(result), 104'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
